// File: rtl/chain_pkg.sv
// Shared types for the delay-chain feeder: lane vector, feeder FSM states, count width helper.
package chain_pkg;

  localparam int CHAIN_DWIDTH = 8;
  localparam int CHAIN_LANES  = 4;

  typedef logic [CHAIN_LANES-1:0][CHAIN_DWIDTH-1:0] lane_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } feeder_state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chain_feeder_fifo.sv
// Synchronous FIFO of an arbitrary packed type; head is shown combinationally from the read pointer.
// Latency: a push is visible at the head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
module chain_feeder_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = chain_pkg::lane_vec_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            push_dat,
  input  logic        pop,
  output T            pop_dat,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  // Extra MSB on each pointer separates full from empty when the low bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/chain_feeder.sv
// Feeds buffered lane vectors into the delay chain and freezes once DEPTH shifts form a window.
// Latency: 2 cycles input-to-chain minimum. Backpressure: o_ready drops when the FIFO is full; ack releases the window.
// CHAIN_FEEDER_SLIDE_EN: sliding window (stride 1) on ack; tumbling window when undefined.
module chain_feeder
  import chain_pkg::*;
#(
  parameter int  DWIDTH     = 8,
  parameter int  LANES      = 4,
  parameter int  DEPTH      = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int CW         = count_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [LANES-1:0][DWIDTH-1:0]  i_data,
  output logic                          o_ready,
  output logic                          o_chain_en,
  output logic [LANES-1:0][DWIDTH-1:0]  o_chain_data,
  output logic                          o_window_valid,
  input  logic                          i_window_ack,
  output logic [CW-1:0]                 o_fill_count
);

  typedef logic [LANES-1:0][DWIDTH-1:0] vec_t;

`ifdef CHAIN_FEEDER_SLIDE_EN
  localparam logic [CW-1:0] ACK_FILL = CW'(DEPTH - 1);
`else
  localparam logic [CW-1:0] ACK_FILL = '0;
`endif

  localparam int FAW = $clog2(FIFO_DEPTH);

  feeder_state_e state;
  feeder_state_e state_nxt;

  logic         rdy_en;
  logic         push;
  logic         pop;
  logic         ack_take;
  logic         fifo_full;
  logic         fifo_empty;
  logic [FAW:0] fifo_count;
  vec_t         fifo_head;
  logic         unused_fifo_count;

  // Holds o_ready low through reset, independent of the FIFO flags.
  always_ff @(posedge clk) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  assign o_ready           = rdy_en && !fifo_full;
  assign push              = i_valid && o_ready;
  assign unused_fifo_count = ^fifo_count;

  chain_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (vec_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (i_data),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ack_take  = 1'b0;
    case (state)
      FILL: begin
        pop = !fifo_empty && (o_fill_count < CW'(DEPTH));
        if (pop && (o_fill_count == CW'(DEPTH - 1))) state_nxt = HOLD;
      end
      HOLD: begin
        ack_take = i_window_ack;
        if (i_window_ack) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Window valid trails the final shift by one edge, so it rises once the chain holds that vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_chain_en     <= 1'b0;
      o_chain_data   <= '0;
      o_window_valid <= 1'b0;
      o_fill_count   <= '0;
    end else begin
      o_chain_en     <= pop;
      o_window_valid <= (state == HOLD) && !i_window_ack;
      if (pop) begin
        o_chain_data <= fifo_head;
        o_fill_count <= o_fill_count + 1'b1;
      end else if (ack_take) begin
        o_fill_count <= ACK_FILL;
      end
    end
  end

endmodule

// File: tb/tb_chain_feeder.sv
// Directed plus randomized bench for chain_feeder against a queue-based window model.
module tb_chain_feeder;
  import chain_pkg::*;

  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int DEPTH = 4;
  localparam int FD    = 4;
  localparam int CW    = count_width(DEPTH);
`ifdef CHAIN_FEEDER_SLIDE_EN
  localparam int ACK_FILL = DEPTH - 1;
`else
  localparam int ACK_FILL = 0;
`endif

  typedef logic [LN-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_window_ack = 1'b0;
  vec_t          i_data = '0;
  logic          o_ready;
  logic          o_chain_en;
  vec_t          o_chain_data;
  logic          o_window_valid;
  logic [CW-1:0] o_fill_count;

  chain_feeder #(
    .DWIDTH     (DW),
    .LANES      (LN),
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_chain_en     (o_chain_en),
    .o_chain_data   (o_chain_data),
    .o_window_valid (o_window_valid),
    .i_window_ack   (i_window_ack),
    .o_fill_count   (o_fill_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: buffered vectors, shifts in the current window, whether the window is frozen.
  vec_t mq[$];
  int   m_fill  = 0;
  bit   m_hold  = 0;
  bit   m_en    = 0;
  bit   m_wv    = 0;
  bit   m_ready = 0;
  bit   m_live  = 0;
  vec_t m_data  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit do_pop;
    bit do_push;
    bit was_hold;
    if (!rst) begin
      mq.delete();
      m_fill = 0;
      m_hold = 0;
      m_en   = 0;
      m_data = '0;
      m_wv   = 0;
      m_live = 0;
    end else begin
      was_hold = m_hold;
      do_pop   = !m_hold && (mq.size() > 0) && (m_fill < DEPTH);
      do_push  = i_valid && m_ready;
      m_en     = do_pop;
      if (do_pop) begin
        m_data = mq.pop_front();
        m_fill++;
        if (m_fill == DEPTH) m_hold = 1;
      end
      if (do_push) mq.push_back(i_data);
      if (was_hold && i_window_ack) begin
        m_hold = 0;
        m_fill = ACK_FILL;
      end
      m_wv   = was_hold && !i_window_ack;
      m_live = 1;
    end
    m_ready = m_live && (mq.size() < FD);
  endtask

  task automatic check_all();
    chk("ready",        o_ready,        m_ready);
    chk("chain_en",     o_chain_en,     m_en);
    chk("chain_data",   o_chain_data,   m_data);
    chk("window_valid", o_window_valid, m_wv);
    chk("fill_count",   o_fill_count,   m_fill);
  endtask

  task automatic cyc(input bit v, input vec_t d, input bit a, input bit r = 1'b1);
    @(negedge clk);
    rst          = r;
    i_valid      = v;
    i_data       = d;
    i_window_ack = a;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int acc;
    vec_t rv;

    // Reset held with valid asserted.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, '1, 1'b0, 1'b0);
      chk("rst_ready_low", o_ready, 0);
      chk("rst_fill", o_fill_count, 0);
    end
    cyc(1'b0, '0, 1'b0);
    chk("ready_after_rst", o_ready, 1);

    // Basic window 1..4.
    for (int k = 1; k <= 4; k++) cyc(1'b1, vec_t'(k), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("win_last_en", o_chain_en, 1);
    chk("win_last_data", o_chain_data, 4);
    cyc(1'b0, '0, 1'b0);
    chk("win_valid", o_window_valid, 1);
    chk("win_fill", o_fill_count, 4);
    chk("win_en_off", o_chain_en, 0);

    // Backpressure with the window held.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_ready) acc++;
      cyc(1'b1, vec_t'(10 + k), 1'b0);
    end
    chk("bp_accept", acc, 4);
    chk("bp_ready_low", o_ready, 0);
    cyc(1'b0, '0, 1'b1);
    chk("ack_ready_still_low", o_ready, 0);
    cyc(1'b0, '0, 1'b0);
    chk("ready_after_pop", o_ready, 1);
    chk("pop_data", o_chain_data, 10);

    // Drain, acking every presented window.
    for (int k = 0; k < 20; k++) cyc(1'b0, '0, o_window_valid);
    cyc(1'b1, vec_t'(5), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("v5_en", o_chain_en, 1);
    chk("v5_data", o_chain_data, 5);
    cyc(1'b0, '0, 1'b0);
`ifdef CHAIN_FEEDER_SLIDE_EN
    chk("slide_wv", o_window_valid, 1);
    chk("slide_fill", o_fill_count, 4);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, vec_t'(6), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("slide2_wv", o_window_valid, 1);
    chk("slide2_data", o_chain_data, 6);
`else
    chk("tumble_wv_low", o_window_valid, 0);
    chk("tumble_fill1", o_fill_count, 1);
    for (int k = 6; k <= 8; k++) cyc(1'b1, vec_t'(k), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("tumble_data8", o_chain_data, 8);
    cyc(1'b0, '0, 1'b0);
    chk("tumble_wv", o_window_valid, 1);
    chk("tumble_fill4", o_fill_count, 4);
`endif

    // Mid-window reset.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, vec_t'(31), 1'b0);
    cyc(1'b1, vec_t'(32), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, vec_t'(33), 1'b0, 1'b0);
    chk("mrst_fill", o_fill_count, 0);
    chk("mrst_wv", o_window_valid, 0);
    chk("mrst_en", o_chain_en, 0);
    cyc(1'b0, '0, 1'b0);
    chk("mrst_ready", o_ready, 1);
    for (int k = 21; k <= 24; k++) cyc(1'b1, vec_t'(k), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("fresh_data", o_chain_data, 24);
    cyc(1'b0, '0, 1'b0);
    chk("fresh_wv", o_window_valid, 1);
    chk("fresh_fill", o_fill_count, 4);

    // Randomized traffic with occasional resets and stray acks.
    for (int k = 0; k < 400; k++) begin
      rv = vec_t'({$urandom, $urandom});
      cyc($urandom_range(9) < 6, rv, $urandom_range(1) == 1, $urandom_range(99) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
